// File: rtl/trap_ctrl_unit.sv
// trap_ctrl_unit: machine-mode trap controller beside the MEM stage.
// Owns mstatus/mie/mip/mtvec/mepc/mcause/mtval, synchronises and
// priority-encodes NUM_IRQ interrupt lines, arbitrates them against
// synchronous exceptions and sequences trap entry / mret.
// Optional feature macro: TRAP_VECTORED_EN (vectored interrupt mode).
// Ports:
//   clk, rst                  clock, async active-high reset
//   csr_*                     CSR access from the MEM instruction
//   csr_r_data_out            combinational CSR read (old value)
//   irq_in                    async level interrupt requests
//   illegal_inst, ecall_m,
//   l_access_fault,
//   s_access_fault, mret      events of the MEM instruction
//   fault_addr, epc_cur,
//   epc_next                  trap value / return PC sources
//   PC_redirect, redirect_mux redirect target and select
//   reg_*_flush               pipeline register flushes
//   RegWrite_cancel           kill writeback of trapping instruction
//   trap_busy                 FSM not idle
module trap_ctrl_unit #(
  parameter int XLEN            = 32,
  parameter int NUM_IRQ         = 8,
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_rw_in,
  input  logic [1:0]         csr_wsc_mode_in,
  input  logic               csr_w_imm_mux,
  input  logic [11:0]        csr_rw_addr_in,
  input  logic [XLEN-1:0]    csr_w_data_reg,
  input  logic [4:0]         csr_w_data_imm,
  output logic [XLEN-1:0]    csr_r_data_out,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               illegal_inst,
  input  logic               ecall_m,
  input  logic               l_access_fault,
  input  logic               s_access_fault,
  input  logic               mret,
  input  logic [XLEN-1:0]    fault_addr,
  input  logic [XLEN-1:0]    epc_cur,
  input  logic [XLEN-1:0]    epc_next,
  output logic [XLEN-1:0]    PC_redirect,
  output logic               redirect_mux,
  output logic               reg_FD_flush,
  output logic               reg_DE_flush,
  output logic               reg_EM_flush,
  output logic               reg_MW_flush,
  output logic               RegWrite_cancel,
  output logic               trap_busy
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;
  localparam logic [11:0] A_MIP     = 12'h344;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRAP,
    S_RET
  } state_t;

  state_t state_q, state_d;

  logic               mstat_mie_q;
  logic               mstat_mpie_q;
  logic [NUM_IRQ-1:0] mie_q;
  logic [XLEN-3:0]    mtvec_base_q;
  logic [XLEN-1:0]    mepc_q;
  logic [XLEN-1:0]    mcause_q;
  logic [XLEN-1:0]    mtval_q;
`ifdef TRAP_VECTORED_EN
  logic               mtvec_mode_q;
`endif

  logic [NUM_IRQ-1:0] sync_q [IRQ_SYNC_STAGES];
  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] irq_p;
  logic [3:0]         irq_idx;
  logic [4:0]         irq_code;
  logic               irq_take;

  logic               exc_any;
  logic [4:0]         exc_code;
  logic [XLEN-1:0]    exc_tval;

  logic               is_idle;
  logic               trap_take;
  logic               ret_take;

  logic [XLEN-1:0]    rdata;
  logic [XLEN-1:0]    wdata;
  logic [XLEN-1:0]    new_val;
  logic               csr_we;
  logic [1:0]         mtvec_mode;
  logic [XLEN-1:0]    vec_base;
  logic [XLEN-1:0]    trap_vec;

  // irq synchroniser chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < IRQ_SYNC_STAGES; s++)
        sync_q[s] <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < IRQ_SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

  assign irq_s = sync_q[IRQ_SYNC_STAGES-1];
  assign irq_p = irq_s & mie_q;

  // lowest pending index wins: scan downward so the last hit is lowest
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (irq_p[i]) irq_idx = 4'(i);
  end

  assign irq_code = 5'd16 + {1'b0, irq_idx};
  assign irq_take = mstat_mie_q & (|irq_p);

  always_comb begin
    exc_code = '0;
    exc_tval = '0;
    priority case (1'b1)
      illegal_inst: begin
        exc_code = 5'd2;
        exc_tval = epc_cur;
      end
      ecall_m: begin
        exc_code = 5'd11;
      end
      l_access_fault: begin
        exc_code = 5'd5;
        exc_tval = fault_addr;
      end
      s_access_fault: begin
        exc_code = 5'd7;
        exc_tval = fault_addr;
      end
      default: ;
    endcase
  end

  assign exc_any = illegal_inst | ecall_m |
                   l_access_fault | s_access_fault;

  assign is_idle   = (state_q == S_IDLE);
  assign trap_take = is_idle & (exc_any | irq_take);
  assign ret_take  = is_idle & mret & ~exc_any & ~irq_take;

`ifdef TRAP_VECTORED_EN
  assign mtvec_mode = {1'b0, mtvec_mode_q};
`else
  assign mtvec_mode = 2'b00;
`endif

  // CSR read mux
  always_comb begin
    rdata = '0;
    unique case (csr_rw_addr_in)
      A_MSTATUS: begin
        rdata[3] = mstat_mie_q;
        rdata[7] = mstat_mpie_q;
      end
      A_MIE:    rdata[16+NUM_IRQ-1:16] = mie_q;
      A_MTVEC:  rdata = {mtvec_base_q, mtvec_mode};
      A_MEPC:   rdata = mepc_q;
      A_MCAUSE: rdata = mcause_q;
      A_MTVAL:  rdata = mtval_q;
      A_MIP:    rdata[16+NUM_IRQ-1:16] = irq_s;
      default:  rdata = '0;
    endcase
  end

  assign csr_r_data_out = rdata;

  assign wdata = csr_w_imm_mux ?
                 {{(XLEN-5){1'b0}}, csr_w_data_imm} :
                 csr_w_data_reg;

  always_comb begin
    new_val = rdata;
    unique case (csr_wsc_mode_in)
      2'b01:   new_val = wdata;
      2'b10:   new_val = rdata | wdata;
      2'b11:   new_val = rdata & ~wdata;
      default: new_val = rdata;
    endcase
  end

  // trap/mret acceptance takes precedence over a CSR write
  assign csr_we = csr_rw_in & (|csr_wsc_mode_in) & is_idle &
                  ~trap_take & ~ret_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstat_mie_q  <= 1'b0;
      mstat_mpie_q <= 1'b0;
      mie_q        <= '0;
      mtvec_base_q <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
`ifdef TRAP_VECTORED_EN
      mtvec_mode_q <= 1'b0;
`endif
    end else if (trap_take) begin
      mstat_mpie_q <= mstat_mie_q;
      mstat_mie_q  <= 1'b0;
      if (exc_any) begin
        mepc_q   <= epc_cur;
        mcause_q <= {{(XLEN-5){1'b0}}, exc_code};
        mtval_q  <= exc_tval;
      end else begin
        mepc_q   <= epc_next;
        mcause_q <= {1'b1, {(XLEN-6){1'b0}}, irq_code};
        mtval_q  <= '0;
      end
    end else if (ret_take) begin
      mstat_mie_q  <= mstat_mpie_q;
      mstat_mpie_q <= 1'b1;
    end else if (csr_we) begin
      unique case (csr_rw_addr_in)
        A_MSTATUS: begin
          mstat_mie_q  <= new_val[3];
          mstat_mpie_q <= new_val[7];
        end
        A_MIE:    mie_q <= new_val[16+NUM_IRQ-1:16];
        A_MTVEC: begin
          mtvec_base_q <= new_val[XLEN-1:2];
`ifdef TRAP_VECTORED_EN
          // reserved modes 2/3 collapse to direct
          mtvec_mode_q <= (new_val[1:0] == 2'b01);
`endif
        end
        A_MEPC:   mepc_q   <= {new_val[XLEN-1:2], 2'b00};
        A_MCAUSE: mcause_q <= new_val;
        A_MTVAL:  mtval_q  <= new_val;
        default: ;
      endcase
    end
  end

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (trap_take)     state_d = S_TRAP;
        else if (ret_take) state_d = S_RET;
      end
      S_TRAP:  state_d = S_IDLE;
      S_RET:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign vec_base = {mtvec_base_q, 2'b00};

`ifdef TRAP_VECTORED_EN
  // mcause is already latched during TRAP, so it selects the slot
  assign trap_vec = (mtvec_mode_q && mcause_q[XLEN-1]) ?
                    vec_base +
                    {{(XLEN-7){1'b0}}, mcause_q[4:0], 2'b00} :
                    vec_base;
`else
  assign trap_vec = vec_base;
`endif

  always_comb begin
    PC_redirect = '0;
    unique case (state_q)
      S_TRAP:  PC_redirect = trap_vec;
      S_RET:   PC_redirect = mepc_q;
      default: PC_redirect = '0;
    endcase
  end

  assign trap_busy       = ~is_idle;
  assign redirect_mux    = ~is_idle;
  assign reg_FD_flush    = ~is_idle;
  assign reg_DE_flush    = ~is_idle;
  assign reg_EM_flush    = ~is_idle;
  assign reg_MW_flush    = ~is_idle;
  assign RegWrite_cancel = (state_q == S_TRAP);

endmodule

// File: tb/tb_trap_ctrl_unit.sv
// tb_trap_ctrl_unit: directed scoreboard bench for trap_ctrl_unit.
// Expected values are queued at stimulus time and popped at output.
module tb_trap_ctrl_unit;

  localparam int NI = 8;

  logic          clk;
  logic          rst;
  logic          csr_rw_in;
  logic [1:0]    csr_wsc_mode_in;
  logic          csr_w_imm_mux;
  logic [11:0]   csr_rw_addr_in;
  logic [31:0]   csr_w_data_reg;
  logic [4:0]    csr_w_data_imm;
  logic [31:0]   csr_r_data_out;
  logic [NI-1:0] irq_in;
  logic          illegal_inst;
  logic          ecall_m;
  logic          l_access_fault;
  logic          s_access_fault;
  logic          mret;
  logic [31:0]   fault_addr;
  logic [31:0]   epc_cur;
  logic [31:0]   epc_next;
  logic [31:0]   PC_redirect;
  logic          redirect_mux;
  logic          reg_FD_flush;
  logic          reg_DE_flush;
  logic          reg_EM_flush;
  logic          reg_MW_flush;
  logic          RegWrite_cancel;
  logic          trap_busy;

  trap_ctrl_unit #(
    .XLEN(32),
    .NUM_IRQ(NI),
    .IRQ_SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .csr_rw_in(csr_rw_in),
    .csr_wsc_mode_in(csr_wsc_mode_in),
    .csr_w_imm_mux(csr_w_imm_mux),
    .csr_rw_addr_in(csr_rw_addr_in),
    .csr_w_data_reg(csr_w_data_reg),
    .csr_w_data_imm(csr_w_data_imm),
    .csr_r_data_out(csr_r_data_out),
    .irq_in(irq_in),
    .illegal_inst(illegal_inst),
    .ecall_m(ecall_m),
    .l_access_fault(l_access_fault),
    .s_access_fault(s_access_fault),
    .mret(mret),
    .fault_addr(fault_addr),
    .epc_cur(epc_cur),
    .epc_next(epc_next),
    .PC_redirect(PC_redirect),
    .redirect_mux(redirect_mux),
    .reg_FD_flush(reg_FD_flush),
    .reg_DE_flush(reg_DE_flush),
    .reg_EM_flush(reg_EM_flush),
    .reg_MW_flush(reg_MW_flush),
    .RegWrite_cancel(RegWrite_cancel),
    .trap_busy(trap_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  // {redirect, FD, DE, EM, MW, cancel, busy}
  localparam logic [31:0] ST_IDLE = 32'h00;
  localparam logic [31:0] ST_TRAP = 32'h7F;
  localparam logic [31:0] ST_RET  = 32'h7D;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] MTVEC_RB = 32'h101;
  localparam logic [31:0] IRQ3_PC  = 32'h14C;
`else
  localparam logic [31:0] MTVEC_RB = 32'h100;
  localparam logic [31:0] IRQ3_PC  = 32'h100;
`endif

  function automatic logic [31:0] st();
    return {25'd0, redirect_mux, reg_FD_flush, reg_DE_flush,
            reg_EM_flush, reg_MW_flush, RegWrite_cancel,
            trap_busy};
  endfunction

  task automatic expect_v(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%h expected=none",
             obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] m,
                    input logic [31:0] d);
    @(negedge clk);
    csr_rw_in       = 1'b1;
    csr_wsc_mode_in = m;
    csr_rw_addr_in  = a;
    csr_w_data_reg  = d;
    csr_w_imm_mux   = 1'b0;
    @(negedge clk);
    csr_rw_in       = 1'b0;
    csr_wsc_mode_in = 2'b00;
  endtask

  task automatic wri(input logic [11:0] a, input logic [1:0] m,
                     input logic [4:0] z);
    @(negedge clk);
    csr_rw_in       = 1'b1;
    csr_wsc_mode_in = m;
    csr_rw_addr_in  = a;
    csr_w_data_imm  = z;
    csr_w_imm_mux   = 1'b1;
    @(negedge clk);
    csr_rw_in       = 1'b0;
    csr_wsc_mode_in = 2'b00;
    csr_w_imm_mux   = 1'b0;
  endtask

  task automatic rd_chk(input string t, input logic [11:0] a,
                        input logic [31:0] e);
    expect_v(t, e);
    csr_rw_addr_in = a;
    #1;
    check(csr_r_data_out);
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    rst             = 1'b1;
    csr_rw_in       = 1'b0;
    csr_wsc_mode_in = 2'b00;
    csr_w_imm_mux   = 1'b0;
    csr_rw_addr_in  = 12'h0;
    csr_w_data_reg  = 32'h0;
    csr_w_data_imm  = 5'h0;
    irq_in          = '0;
    illegal_inst    = 1'b0;
    ecall_m         = 1'b0;
    l_access_fault  = 1'b0;
    s_access_fault  = 1'b0;
    mret            = 1'b0;
    fault_addr      = 32'h0;
    epc_cur         = 32'h0;
    epc_next        = 32'h0;

    // reset state
    repeat (2) @(negedge clk);
    expect_v("rst_status", ST_IDLE);
    check(st());
    expect_v("rst_pc", 32'h0);
    check(PC_redirect);
    rd_chk("rst_mtvec", 12'h305, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // mtvec + illegal instruction trap
    wr(12'h305, 2'b01, 32'h100);
    rd_chk("mtvec_rb0", 12'h305, 32'h100);
    @(negedge clk);
    illegal_inst = 1'b1;
    epc_cur      = 32'h40;
    expect_v("ill_status", ST_TRAP);
    expect_v("ill_pc", 32'h100);
    tick();
    check(st());
    check(PC_redirect);
    // ecall during the TRAP cycle must be ignored
    @(negedge clk);
    illegal_inst = 1'b0;
    ecall_m      = 1'b1;
    expect_v("ill_exit", ST_IDLE);
    tick();
    check(st());
    @(negedge clk);
    ecall_m = 1'b0;
    rd_chk("ill_mepc", 12'h341, 32'h40);
    rd_chk("ill_mcause", 12'h342, 32'h2);
    rd_chk("ill_mtval", 12'h343, 32'h40);
    rd_chk("ill_mstatus", 12'h300, 32'h0);

    // mret: MPIE=1 restores MIE
    wr(12'h300, 2'b01, 32'h80);
    @(negedge clk);
    mret = 1'b1;
    expect_v("ret_status", ST_RET);
    expect_v("ret_pc", 32'h40);
    tick();
    check(st());
    check(PC_redirect);
    @(negedge clk);
    mret = 1'b0;
    expect_v("ret_exit", ST_IDLE);
    tick();
    check(st());
    @(negedge clk);
    rd_chk("ret_mstatus", 12'h300, 32'h88);

    // irq 2 through the synchroniser
    wr(12'h304, 2'b01, 32'h40000);
    @(negedge clk);
    irq_in   = 8'h04;
    epc_next = 32'h200;
    expect_v("irq_e1", ST_IDLE);
    tick();
    check(st());
    expect_v("irq_e2", ST_IDLE);
    tick();
    check(st());
    rd_chk("irq_mip", 12'h344, 32'h40000);
    expect_v("irq_status", ST_TRAP);
    expect_v("irq_pc", 32'h100);
    tick();
    check(st());
    check(PC_redirect);
    @(negedge clk);
    irq_in = '0;
    tick();
    @(negedge clk);
    rd_chk("irq_mcause", 12'h342, 32'h8000_0012);
    rd_chk("irq_mepc", 12'h341, 32'h200);
    rd_chk("irq_mtval", 12'h343, 32'h0);
    rd_chk("irq_mstatus", 12'h300, 32'h80);
    repeat (3) @(negedge clk);

    // lowest-index irq wins
    wr(12'h304, 2'b01, 32'h220000);
    wr(12'h300, 2'b01, 32'h8);
    @(negedge clk);
    irq_in = 8'h22;
    repeat (2) tick();
    expect_v("prio_status", ST_TRAP);
    tick();
    check(st());
    @(negedge clk);
    irq_in = '0;
    tick();
    @(negedge clk);
    rd_chk("prio_mcause", 12'h342, 32'h8000_0011);
    repeat (3) @(negedge clk);

    // exception beats a simultaneous interrupt
    wr(12'h300, 2'b01, 32'h8);
    @(negedge clk);
    irq_in = 8'h22;
    repeat (2) tick();
    @(negedge clk);
    ecall_m = 1'b1;
    epc_cur = 32'h80;
    expect_v("ec_status", ST_TRAP);
    tick();
    check(st());
    @(negedge clk);
    ecall_m = 1'b0;
    irq_in  = '0;
    tick();
    @(negedge clk);
    rd_chk("ec_mcause", 12'h342, 32'hB);
    rd_chk("ec_mepc", 12'h341, 32'h80);
    rd_chk("ec_mtval", 12'h343, 32'h0);
    repeat (3) @(negedge clk);

    // irq pulse while masked leaves nothing latched
    @(negedge clk);
    irq_in = 8'h02;
    tick();
    @(negedge clk);
    irq_in = '0;
    repeat (4) tick();
    wr(12'h300, 2'b01, 32'h8);
    repeat (3) begin
      expect_v("nolatch", ST_IDLE);
      tick();
      check(st());
    end
    @(negedge clk);
    rd_chk("nolatch_mst", 12'h300, 32'h8);

    // CSR set / clear / immediate / unmapped / mepc alignment
    wr(12'h304, 2'b01, 32'h0);
    wr(12'h304, 2'b10, 32'h30000);
    rd_chk("mie_set", 12'h304, 32'h30000);
    wr(12'h304, 2'b11, 32'h10000);
    rd_chk("mie_clr", 12'h304, 32'h20000);
    wri(12'h300, 2'b11, 5'h08);
    rd_chk("msti_clr", 12'h300, 32'h0);
    wri(12'h300, 2'b10, 5'h08);
    rd_chk("msti_set", 12'h300, 32'h8);
    wr(12'h7C0, 2'b01, 32'hFFFF_FFFF);
    rd_chk("unmapped", 12'h7C0, 32'h0);
    wr(12'h341, 2'b01, 32'h123);
    rd_chk("mepc_align", 12'h341, 32'h120);

    // vectored mode (or direct when the feature is absent)
    wr(12'h305, 2'b01, 32'h101);
    rd_chk("mtvec_rb1", 12'h305, MTVEC_RB);
    wr(12'h304, 2'b01, 32'h80000);
    @(negedge clk);
    irq_in   = 8'h08;
    epc_next = 32'h300;
    repeat (2) tick();
    expect_v("vec_status", ST_TRAP);
    expect_v("vec_pc", IRQ3_PC);
    tick();
    check(st());
    check(PC_redirect);
    @(negedge clk);
    irq_in = '0;
    tick();
    @(negedge clk);
    rd_chk("vec_mcause", 12'h342, 32'h8000_0013);
    repeat (3) @(negedge clk);

    // exceptions always use the base
    @(negedge clk);
    l_access_fault = 1'b1;
    fault_addr     = 32'hDEAD_0000;
    epc_cur        = 32'h90;
    expect_v("lf_pc", 32'h100);
    tick();
    check(PC_redirect);
    @(negedge clk);
    l_access_fault = 1'b0;
    tick();
    @(negedge clk);
    rd_chk("lf_mtval", 12'h343, 32'hDEAD_0000);
    rd_chk("lf_mcause", 12'h342, 32'h5);

    // reset in the middle of TRAP
    @(negedge clk);
    s_access_fault = 1'b1;
    expect_v("sf_status", ST_TRAP);
    tick();
    check(st());
    rst = 1'b1;
    #1;
    expect_v("rstmid_status", ST_IDLE);
    check(st());
    expect_v("rstmid_pc", 32'h0);
    check(PC_redirect);
    rd_chk("rstmid_mcause", 12'h342, 32'h0);
    s_access_fault = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    expect_v("post_rst", ST_IDLE);
    tick();
    check(st());

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
